// File: rtl/bsg_mem_1r1w_one_hot_byte_ctrl.sv
// Request-side controller for a byte-masked, one-hot-addressed 1r1w register file:
// one-entry write buffer, one-hot encode, read forwarding and a registered read response.
module bsg_mem_1r1w_one_hot_byte_ctrl #(
  parameter int width_p       = 32,
  parameter int els_p         = 8,
  parameter int lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int mask_width_lp = width_p >> 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [lg_els_lp-1:0]     addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] mask_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic [els_p-1:0]         mem_w_v_o,
  output logic [width_p-1:0]       mem_w_data_o,
  output logic [mask_width_lp-1:0] mem_w_mask_o,
  output logic [els_p-1:0]         mem_r_v_o,
  input  logic [width_p-1:0]       mem_r_data_i
);

  // Handshake: a request is taken on any edge where v_i & ready_o; the response is
  // offered while v_o and retired on an edge where yumi_i is high.
  localparam logic [lg_els_lp:0] els_lp = (lg_els_lp + 1)'(els_p);

  logic                     wb_v;
  logic [lg_els_lp-1:0]     wb_addr;
  logic [width_p-1:0]       wb_data;
  logic [mask_width_lp-1:0] wb_mask;

  logic                     accept;
  logic                     w_accept;
  logic                     r_accept;
  logic                     addr_in_range;
  logic                     fwd_hit;
  logic [width_p-1:0]       merged_data;

  assign ready_o       = ~v_o | yumi_i;
  assign accept        = v_i & ready_o;
  assign w_accept      = accept & w_i;
  assign r_accept      = accept & ~w_i;
  assign addr_in_range = ({1'b0, addr_i} < els_lp);
  assign fwd_hit       = wb_v & (wb_addr == addr_i);

  assign mem_w_data_o = wb_data;
  assign mem_w_mask_o = wb_mask;

  // Write enables are masked during reset so a buffered write is dropped, not committed.
  always_comb begin
    mem_w_v_o = '0;
    mem_r_v_o = '0;
    for (int i = 0; i < els_p; i++) begin
      mem_w_v_o[i] = wb_v & ~reset_i & (wb_addr == lg_els_lp'(i));
      mem_r_v_o[i] = v_i & ~w_i & (addr_i == lg_els_lp'(i));
    end
  end

  // The buffered write lands at the same edge the read samples memory, so merge it here.
  always_comb begin
    merged_data = '0;
    for (int b = 0; b < mask_width_lp; b++) begin
      if (addr_in_range) begin
        merged_data[8*b +: 8] = (fwd_hit & wb_mask[b]) ? wb_data[8*b +: 8]
                                                       : mem_r_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_v    <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_mask <= '0;
      v_o     <= 1'b0;
      data_o  <= '0;
    end else begin
      wb_v <= w_accept;
      if (w_accept) begin
        wb_addr <= addr_i;
        wb_data <= data_i;
        wb_mask <= mask_i;
      end
      if (r_accept) begin
        v_o    <= 1'b1;
        data_o <= merged_data;
      end else if (yumi_i) begin
        v_o <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o)) else $error("yumi_i asserted without v_o");
      assert (!(v_i && !w_i && !addr_in_range)) else $error("read address out of range");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_one_hot_byte_ctrl.sv
// Directed bench for bsg_mem_1r1w_one_hot_byte_ctrl with a behavioural memory array
// and scoreboard queues for read responses and memory write commits.
module tb_bsg_mem_1r1w_one_hot_byte_ctrl;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int LG = 3;
  localparam int M  = 4;

  logic          clk;
  logic          reset_i;
  logic          v_i;
  logic          ready_o;
  logic          w_i;
  logic [LG-1:0] addr_i;
  logic [W-1:0]  data_i;
  logic [M-1:0]  mask_i;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          yumi_i;
  logic [N-1:0]  mem_w_v_o;
  logic [W-1:0]  mem_w_data_o;
  logic [M-1:0]  mem_w_mask_o;
  logic [N-1:0]  mem_r_v_o;
  logic [W-1:0]  mem_r_data_i;

  logic [W-1:0]  mem [N];

  logic [W-1:0]       exp_q[$];
  logic [N+W+M-1:0]   wexp_q[$];

  int checks = 0;
  int errors = 0;

  bsg_mem_1r1w_one_hot_byte_ctrl #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .w_i(w_i),
    .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i), .v_o(v_o), .data_o(data_o),
    .yumi_i(yumi_i), .mem_w_v_o(mem_w_v_o), .mem_w_data_o(mem_w_data_o),
    .mem_w_mask_o(mem_w_mask_o), .mem_r_v_o(mem_r_v_o), .mem_r_data_i(mem_r_data_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memory: byte-masked synchronous write, one-hot asynchronous read
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (mem_w_v_o[i])
        for (int b = 0; b < M; b++)
          if (mem_w_mask_o[b]) mem[i][8*b +: 8] <= mem_w_data_o[8*b +: 8];
  end

  always_comb begin
    mem_r_data_i = '0;
    for (int i = 0; i < N; i++)
      if (mem_r_v_o[i]) mem_r_data_i = mem_r_data_i | mem[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitors: pop expected values whenever the DUT presents a response or a write
  always @(negedge clk) begin
    if (!reset_i && v_o && yumi_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected actual=%h required=none", data_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL rsp_data actual=%h required=%h", data_o, e);
        end
      end
    end
    if (mem_w_v_o != '0) begin
      checks++;
      if (wexp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual=%h required=none", mem_w_v_o);
      end else begin
        logic [N+W+M-1:0] e;
        e = wexp_q.pop_front();
        if ({mem_w_v_o, mem_w_data_o, mem_w_mask_o} !== e) begin
          errors++;
          $display("FAIL wr_commit actual=%h required=%h",
                   {mem_w_v_o, mem_w_data_o, mem_w_mask_o}, e);
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [LG-1:0] a,
                       input logic [W-1:0] d, input logic [M-1:0] m, input logic y);
    v_i    = v;
    w_i    = w;
    addr_i = a;
    data_i = d;
    mask_i = m;
    yumi_i = y & v_o;
  endtask

  task automatic wr(input logic [LG-1:0] a, input logic [W-1:0] d, input logic [M-1:0] m,
                    input logic y);
    drive(1'b1, 1'b1, a, d, m, y);
    wexp_q.push_back({N'(1) << a, d, m});
    tick();
  endtask

  task automatic rd(input logic [LG-1:0] a, input logic [W-1:0] e, input logic y);
    drive(1'b1, 1'b0, a, '0, '0, y);
    exp_q.push_back(e);
    tick();
  endtask

  task automatic idle(input logic y);
    drive(1'b0, 1'b0, '0, '0, '0, y);
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[1] = 32'hCAFEF00D;
    mem[3] = 32'h11223344;
    mem[5] = 32'h5A5A5A5A;
    reset_i = 1'b1;
    v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0; yumi_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_v_o", 64'(v_o), 64'd0);
    check("rst_data_o", 64'(data_o), 64'd0);
    check("rst_mem_w_v", 64'(mem_w_v_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    tick();
    reset_i = 1'b0;

    // write then forwarded read, then a read sourced from memory
    wr(3'd3, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd(3'd3, 32'h11BB33DD, 1'b0);
    rd(3'd3, 32'h11BB33DD, 1'b1);
    idle(1'b1);

    // backpressure: response held, further reads refused
    rd(3'd1, 32'hCAFEF00D, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 3'd5, '0, '0, 1'b0);
      @(negedge clk);
      check("bp_ready", 64'(ready_o), 64'd0);
      check("bp_data_hold", 64'(data_o), 64'hCAFEF00D);
      tick();
    end
    rd(3'd5, 32'h5A5A5A5A, 1'b1);
    idle(1'b1);

    // back-to-back writes, then readback
    wr(3'd0, 32'h10101010, 4'hF, 1'b1);
    wr(3'd1, 32'h21212121, 4'hF, 1'b1);
    wr(3'd2, 32'h32323232, 4'hF, 1'b1);
    idle(1'b1);
    rd(3'd0, 32'h10101010, 1'b1);
    rd(3'd1, 32'h21212121, 1'b1);
    rd(3'd2, 32'h32323232, 1'b1);
    idle(1'b1);

    // zero-mask write modifies nothing, even through forwarding
    wr(3'd3, 32'hFFFFFFFF, 4'h0, 1'b1);
    rd(3'd3, 32'h11BB33DD, 1'b1);
    idle(1'b1);

    // reset while a write is buffered: the write must never reach memory
    drive(1'b1, 1'b1, 3'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    reset_i = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_w_v", 64'(mem_w_v_o), 64'd0);
    tick();
    reset_i = 1'b0;
    idle(1'b0);
    rd(3'd5, 32'h5A5A5A5A, 1'b0);
    idle(1'b1);
    idle(1'b0);

    @(negedge clk);
    check("rsp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("wr_queue_empty", 64'(wexp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_mem_1r1w_one_hot_byte_ctrl.md
# bsg_mem_1r1w_one_hot_byte_ctrl

Request-side controller for a byte-masked, one-hot-addressed 1r1w register-file memory. It accepts binary-addressed read and byte-masked write requests over a valid/ready port. Writes pass through a one-entry write buffer before being driven as one-hot write enables with a byte mask. Reads are issued as one-hot read selects, merged with any pending buffered write, and returned through a registered valid/yumi response port. It sits between a client pipeline and the memory array.

## Interface
- width_p, none (must be set), data width in bits; a multiple of 8
- els_p, none (must be set), number of memory entries
- lg_els_lp, `BSG_SAFE_CLOG2(els_p), binary address width
- mask_width_lp, width_p>>3, bytes per word
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- v_i  in  1  request valid
- ready_o  out  1  request accepted when v_i & ready_o
- w_i  in  1  1 = write, 0 = read
- addr_i  in  lg_els_lp  binary entry address
- data_i  in  width_p  write data
- mask_i  in  mask_width_lp  write byte enables; bit b covers data bits [8b+7:8b]
- v_o  out  1  read response valid
- data_o  out  width_p  read response data
- yumi_i  in  1  consumer takes response; legal only when v_o
- mem_w_v_o  out  els_p  one- or zero-hot write enable
- mem_w_data_o  out  width_p  write data
- mem_w_mask_o  out  mask_width_lp  write byte mask
- mem_r_v_o  out  els_p  one- or zero-hot read select
- mem_r_data_i  in  width_p  asynchronous read data from memory

## Operation
- ready_o = ~v_o | yumi_i, for both reads and writes; independent of v_i, w_i.
- Write buffer registers: wb_v, wb_addr, wb_data, wb_mask.
- Accepted write: at the acceptance edge, load wb_* from addr_i/data_i/mask_i; set wb_v = 1.
- If no write is accepted at an edge, wb_v clears.
- mem_w_v_o = wb_v ? one-hot(wb_addr) : 0.
  - mem_w_data_o = wb_data.
  - mem_w_mask_o = wb_mask.
  - All three are purely from registers.
- Net effect: a write accepted at edge t commits to the memory at edge t+1.
- Back-to-back writes: the old buffered write commits at the same edge the new one loads; none are lost.
- Read:
  - mem_r_v_o = (v_i & ~w_i & in-range addr_i) ? one-hot(addr_i) : 0, combinational.
  - At the acceptance edge, the response register loads merged data.
  - For each byte b, merged data takes wb_data's byte if wb_v & wb_addr==addr_i & wb_mask[b]; otherwise it takes mem_r_data_i's byte.
- Out-of-range address (addr_i >= els_p):
  - A write still loads the buffer, but the one-hot encode is zero, so memory is unchanged.
  - A read returns all-zero data, with no forwarding.
- A zero mask write is accepted and modifies nothing.
- Response register:
  - v_o sets on read acceptance.
  - v_o clears on yumi_i unless a new read is accepted in the same cycle, in which case data_o is replaced.
  - data_o is held stable while v_o & ~yumi_i.
- A write accepted while a response is held does not alter data_o.

## Timing
- Reset values: v_o = 0, data_o = 0, wb_v = 0 (so mem_w_v_o = 0), ready_o = 1.
- Reset mid-operation: the buffered write is discarded (never committed); a pending response is dropped.
- Read latency: accepted at edge t, v_o high in cycle after t; one outstanding response maximum.
- Full-rate throughput: one request per cycle when yumi_i is asserted each cycle v_o is high.
- Read in the cycle after a write to the same address observes the write via forwarding; reads two or more cycles later observe memory.
- Debug-only (translate_off): error if yumi_i & ~v_o; error if v_i & ~w_i is used with addr_i out of range.

## Test plan
- Reset then idle:
  - reset_i high 2 cycles -> v_o=0, data_o=0, mem_w_v_o=0, ready_o=1.
- Write, then read same address next cycle (forwarding), width_p=32, els_p=8:
  - Initialize entry 3 to 0x11223344.
  - Write addr 3, data 0xAABBCCDD, mask 4'b0101.
  - Next cycle read addr 3 -> data_o = 0x11BB33DD the following cycle.
- Read two cycles after the write -> same 0x11BB33DD, sourced from memory.
- Backpressure:
  - Read addr 1 accepted, yumi_i held low 3 cycles -> ready_o=0, data_o stable, no further acceptance.
  - Assert yumi_i with a new read in the same cycle -> v_o stays 1 with new data.
- Back-to-back writes:
  - Write addr 0,1,2 on consecutive cycles, full mask.
  - mem_w_v_o = 0001, 0010, 0100 on the three following cycles.
  - Readback matches.
- Reset mid-operation:
  - Write addr 5 accepted, reset_i asserted the next cycle.
  - mem_w_v_o = 0 during reset; entry 5 unchanged on later read.
